// File: rtl/led_seq_ctrl_if.sv
// Button/pause inputs and LED/status outputs of the LED pattern sequencer.
// master: board-side driver of the buttons; slave: led_seq_ctrl itself.
interface led_seq_ctrl_if;
  logic       btn_go;
  logic       btn_mode;
  logic       pause;
  logic [7:0] LED_Out;
  logic [1:0] mode;
  logic       busy;
  logic       done;

  modport master (
    output btn_go, btn_mode, pause,
    input  LED_Out, mode, busy, done
  );

  modport slave (
    input  btn_go, btn_mode, pause,
    output LED_Out, mode, busy, done
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: debounced go/mode buttons, four patterns, timed runs with pause.
// Define LED_SEQ_LOOP_EN to cycle through modes continuously instead of stopping after a run.
module led_seq_ctrl #(
  parameter int unsigned TICK_CYC  = 2_500_000,
  parameter int unsigned RUN_TICKS = 20,
  parameter int unsigned DB_CYC    = 250_000
) (
  input  logic           CLK,
  input  logic           start,
  led_seq_ctrl_if.slave  bus
);

  localparam logic [31:0] PRESC_LAST = 32'(TICK_CYC - 1);
  localparam logic [15:0] TICK_LAST  = 16'(RUN_TICKS - 1);
  localparam logic [31:0] DB_LAST    = 32'(DB_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  // Button conditioning: index 0 = go, index 1 = mode.
  logic [1:0]  btn_raw;
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  db_lvl_q;
  logic [1:0]  db_pulse_q;
  logic [31:0] db_cnt_q [2];
  logic        go_p, mode_p;

  assign btn_raw = {bus.btn_mode, bus.btn_go};
  assign go_p    = db_pulse_q[0];
  assign mode_p  = db_pulse_q[1];

  always_ff @(posedge CLK or negedge start) begin
    if (!start) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_lvl_q   <= '0;
      db_pulse_q <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      db_pulse_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          // Level accepted; the pulse rides on the same edge so it lands 2+DB_CYC after the input.
          db_cnt_q[i]   <= '0;
          db_lvl_q[i]   <= sync2_q[i];
          db_pulse_q[i] <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  // Sequencer state
  state_t      state_q, state_d;
  logic [7:0]  led_q, led_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] presc_q, presc_d;
  logic [15:0] tick_q, tick_d;
  logic        dir_up_q, dir_up_d;
  logic        done_q, done_d;

  logic [1:0]  mode_inc;
  logic [7:0]  step_led;
  logic        step_up;

  assign mode_inc = mode_q + 2'd1;

  function automatic logic [7:0] seed_of(input logic [1:0] m);
    unique case (m)
      2'd0: seed_of = 8'b0000_1111;
      2'd1: seed_of = 8'b0000_0001;
      2'd2: seed_of = 8'b0000_0001;
      2'd3: seed_of = 8'hFF;
    endcase
  endfunction

  // Next pattern value for one step of the current mode.
  always_comb begin
    step_led = led_q;
    step_up  = dir_up_q;
    unique case (mode_q)
      2'd0: step_led = {led_q[0], led_q[7:1]};
      2'd1: step_led = {led_q[6:0], led_q[7]};
      2'd2: begin
        // Reverse at the ends: up stops at bit7, down stops at bit0.
        step_up  = dir_up_q ? ~led_q[7] : led_q[0];
        step_led = step_up ? {led_q[6:0], 1'b0} : {1'b0, led_q[7:1]};
      end
      2'd3: step_led = ~led_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    dir_up_d = dir_up_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        led_d = '0;
        if (go_p) begin
          state_d  = S_RUN;
          led_d    = seed_of(mode_q);
          presc_d  = '0;
          tick_d   = '0;
          dir_up_d = 1'b1;
        end else if (mode_p) begin
          mode_d = mode_inc;
        end
      end

      S_RUN, S_PAUSE: begin
        if (go_p) begin
`ifdef LED_SEQ_LOOP_EN
          state_d = S_IDLE;
          led_d   = '0;
          presc_d = '0;
          tick_d  = '0;
`else
          state_d  = S_RUN;
          led_d    = seed_of(mode_q);
          presc_d  = '0;
          tick_d   = '0;
          dir_up_d = 1'b1;
`endif
        end else if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (state_q == S_PAUSE) begin
          // Resume edge does not count; the prescaler continues from its held value next cycle.
          state_d = S_RUN;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (tick_q == TICK_LAST) begin
`ifdef LED_SEQ_LOOP_EN
            mode_d   = mode_inc;
            led_d    = seed_of(mode_inc);
            tick_d   = '0;
            dir_up_d = 1'b1;
            done_d   = 1'b1;
`else
            state_d = S_DONE;
            led_d   = '0;
            tick_d  = '0;
            done_d  = 1'b1;
`endif
          end else begin
            led_d    = step_led;
            dir_up_d = step_up;
            tick_d   = tick_q + 16'd1;
          end
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge start) begin
    if (!start) begin
      state_q  <= S_IDLE;
      led_q    <= '0;
      mode_q   <= '0;
      presc_q  <= '0;
      tick_q   <= '0;
      dir_up_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      dir_up_q <= dir_up_d;
      done_q   <= done_d;
    end
  end

  assign bus.LED_Out = led_q;
  assign bus.mode    = mode_q;
  assign bus.busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: two instances (5-tick and 16-tick runs) share one stimulus stream.
// Expected LED values come from closed-form pattern arithmetic indexed by step number.
module tb_led_seq_ctrl;
  localparam int unsigned TICK = 4;
  localparam int unsigned DB   = 3;
  localparam int unsigned RT   = 5;
  localparam int unsigned RT16 = 16;

  logic CLK = 1'b0;
  logic start = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  led_seq_ctrl_if bus ();
  led_seq_ctrl_if bus16 ();

  assign bus16.btn_go   = bus.btn_go;
  assign bus16.btn_mode = bus.btn_mode;
  assign bus16.pause    = bus.pause;

  led_seq_ctrl #(.TICK_CYC(TICK), .RUN_TICKS(RT), .DB_CYC(DB)) dut (
    .CLK(CLK), .start(start), .bus(bus)
  );

  led_seq_ctrl #(.TICK_CYC(TICK), .RUN_TICKS(RT16), .DB_CYC(DB)) dut16 (
    .CLK(CLK), .start(start), .bus(bus16)
  );

  always #5 CLK = ~CLK;

  // LED value after k steps of mode m.
  function automatic logic [7:0] exp_led(input int m, input int k);
    logic [15:0] d;
    case (m)
      0: begin
        d = 16'h0F0F >> (k % 8);
        return d[7:0];
      end
      1: return 8'(1 << (k % 8));
      2: return ((k % 14) < 8) ? 8'(1 << (k % 14)) : 8'(1 << (14 - (k % 14)));
      default: return ((k % 2) == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    bus.btn_go = 1'b0;
    bus.btn_mode = 1'b0;
    bus.pause = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    tick();
  endtask

  task automatic press_mode(input int times);
    for (int i = 0; i < times; i++) begin
      bus.btn_mode = 1'b1;
      repeat (8) tick();
      bus.btn_mode = 1'b0;
      repeat (8) tick();
    end
  endtask

  // Returns just after the edge on which the run starts.
  task automatic launch();
    bus.btn_go = 1'b1;
    repeat (6) tick();
    bus.btn_go = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0;
    bus.btn_go = 1'b0;
    bus.btn_mode = 1'b0;
    bus.pause = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.LED_Out, bus.mode, bus.busy, bus.done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected 000", {bus.LED_Out, bus.mode, bus.busy, bus.done});
    end
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if ({bus.LED_Out, bus.mode, bus.busy, bus.done} !== 12'h000) begin
        n_fail++;
        $display("FAIL idle_after_reset cyc %0d: got %h expected 000", i,
                 {bus.LED_Out, bus.mode, bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_bounce();
    int level;
    int left;
    do_reset();
    level = 1;
    left  = 22;
    while (left > 0) begin
      bus.btn_go = level[0];
      for (int r = $urandom_range(1, 2); r > 0 && left > 0; r--) begin
        tick();
        left--;
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL bounce_reject: busy got %b expected 0", bus.busy);
        end
      end
      level = 1 - level;
    end
    bus.btn_go = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.LED_Out !== 8'h00) begin
      n_fail++;
      $display("FAIL bounce_settled: busy %b led %h expected 0 00", bus.busy, bus.LED_Out);
    end
    bus.btn_go = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL press_latency_early: busy got %b expected 0", bus.busy);
    end
    tick();
    n_checks++;
    if ({bus.busy, bus.LED_Out} !== {1'b1, 8'h0F}) begin
      n_fail++;
      $display("FAIL press_latency: got %h expected %h", {bus.busy, bus.LED_Out}, {1'b1, 8'h0F});
    end
    bus.btn_go = 1'b0;
  endtask

  task automatic test_mode0_run();
    do_reset();
    launch();
    for (int n = 0; n < int'(4 * RT); n++) begin
      if (n > 0) tick();
      n_checks++;
      if ({bus.busy, bus.done, bus.LED_Out} !== {1'b1, 1'b0, exp_led(0, n / 4)}) begin
        n_fail++;
        $display("FAIL mode0_step n=%0d: got %h expected %h", n,
                 {bus.busy, bus.done, bus.LED_Out}, {1'b1, 1'b0, exp_led(0, n / 4)});
      end
    end
    tick();
`ifdef LED_SEQ_LOOP_EN
    n_checks++;
    if ({bus.busy, bus.done, bus.mode, bus.LED_Out} !== {1'b1, 1'b1, 2'd1, 8'h01}) begin
      n_fail++;
      $display("FAIL loop_advance: got %h expected %h",
               {bus.busy, bus.done, bus.mode, bus.LED_Out}, {1'b1, 1'b1, 2'd1, 8'h01});
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_done_width: done got %b expected 0", bus.done);
    end
    launch();
    n_checks++;
    if ({bus.busy, bus.LED_Out, bus.mode} !== {1'b0, 8'h00, 2'd1}) begin
      n_fail++;
      $display("FAIL loop_go_stops: got %h expected %h", {bus.busy, bus.LED_Out, bus.mode},
               {1'b0, 8'h00, 2'd1});
    end
`else
    n_checks++;
    if ({bus.busy, bus.done, bus.LED_Out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL run_done: got %h expected %h", {bus.busy, bus.done, bus.LED_Out},
               {1'b0, 1'b1, 8'h00});
    end
    tick();
    n_checks++;
    if ({bus.busy, bus.done, bus.LED_Out, bus.mode} !== {1'b0, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL done_to_idle: got %h expected %h", {bus.busy, bus.done, bus.LED_Out, bus.mode},
               {1'b0, 1'b0, 8'h00, 2'd0});
    end
`endif
  endtask

  task automatic test_patterns16();
    int m;
    for (int it = 0; it < 4; it++) begin
      m = (it == 0) ? 2 : int'($urandom_range(0, 3));
      do_reset();
      press_mode(m);
      n_checks++;
      if (bus16.mode !== 2'(m)) begin
        n_fail++;
        $display("FAIL mode_select: got %0d expected %0d", bus16.mode, m);
      end
      launch();
      for (int n = 0; n < int'(4 * RT16); n++) begin
        if (n > 0) tick();
        n_checks++;
        if ({bus16.busy, bus16.LED_Out} !== {1'b1, exp_led(m, n / 4)}) begin
          n_fail++;
          $display("FAIL pattern m=%0d n=%0d: got %h expected %h", m, n,
                   {bus16.busy, bus16.LED_Out}, {1'b1, exp_led(m, n / 4)});
        end
      end
      tick();
`ifdef LED_SEQ_LOOP_EN
      n_checks++;
      if ({bus16.done, bus16.mode, bus16.LED_Out} !== {1'b1, 2'(m + 1), exp_led((m + 1) % 4, 0)}) begin
        n_fail++;
        $display("FAIL pattern_wrap m=%0d: got %h expected %h", m, {bus16.done, bus16.mode, bus16.LED_Out},
                 {1'b1, 2'(m + 1), exp_led((m + 1) % 4, 0)});
      end
`else
      n_checks++;
      if ({bus16.busy, bus16.done, bus16.LED_Out} !== {1'b0, 1'b1, 8'h00}) begin
        n_fail++;
        $display("FAIL pattern_end m=%0d: got %h expected %h", m,
                 {bus16.busy, bus16.done, bus16.LED_Out}, {1'b0, 1'b1, 8'h00});
      end
`endif
    end
  endtask

  task automatic test_pause();
    int m, j, h, eff;
    m = int'($urandom_range(0, 3));
    j = int'($urandom_range(0, 3));
    h = int'($urandom_range(3, 10));
    do_reset();
    press_mode(m);
    launch();
    repeat (4 * j + 3) tick();
    bus.pause = 1'b1;
    for (int i = 0; i < h; i++) begin
      tick();
      n_checks++;
      if ({bus.busy, bus.LED_Out} !== {1'b1, exp_led(m, j)}) begin
        n_fail++;
        $display("FAIL pause_hold i=%0d: got %h expected %h", i, {bus.busy, bus.LED_Out},
                 {1'b1, exp_led(m, j)});
      end
    end
    bus.pause = 1'b0;
    tick();
    n_checks++;
    if (bus.LED_Out !== exp_led(m, j)) begin
      n_fail++;
      $display("FAIL pause_resume_edge: got %h expected %h", bus.LED_Out, exp_led(m, j));
    end
    eff = 4 * j + 3;
    while (eff < int'(4 * RT) - 1) begin
      tick();
      eff++;
      n_checks++;
      if ({bus.busy, bus.LED_Out} !== {1'b1, exp_led(m, eff / 4)}) begin
        n_fail++;
        $display("FAIL pause_continue eff=%0d: got %h expected %h", eff, {bus.busy, bus.LED_Out},
                 {1'b1, exp_led(m, eff / 4)});
      end
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_run_end: done got %b expected 1", bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int m;
    m = int'($urandom_range(0, 3));
    do_reset();
    press_mode(m);
    launch();
    repeat (5) tick();
    bus.btn_go = 1'b1;
    repeat (5) tick();
    bus.pause = 1'b1;
    tick();
`ifdef LED_SEQ_LOOP_EN
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.busy, bus.LED_Out, bus.mode} !== {1'b0, 8'h00, 2'(m)}) begin
        n_fail++;
        $display("FAIL go_stop i=%0d: got %h expected %h", i, {bus.busy, bus.LED_Out, bus.mode},
                 {1'b0, 8'h00, 2'(m)});
      end
      tick();
    end
    bus.pause = 1'b0;
    bus.btn_go = 1'b0;
`else
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.busy, bus.LED_Out, bus.mode} !== {1'b1, exp_led(m, 0), 2'(m)}) begin
        n_fail++;
        $display("FAIL restart_over_pause i=%0d: got %h expected %h", i,
                 {bus.busy, bus.LED_Out, bus.mode}, {1'b1, exp_led(m, 0), 2'(m)});
      end
      if (i < 3) tick();
    end
    bus.pause = 1'b0;
    bus.btn_go = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (bus.LED_Out !== exp_led(m, 0)) begin
      n_fail++;
      $display("FAIL restart_resume_hold: got %h expected %h", bus.LED_Out, exp_led(m, 0));
    end
    tick();
    n_checks++;
    if (bus.LED_Out !== exp_led(m, 1)) begin
      n_fail++;
      $display("FAIL restart_first_step: got %h expected %h", bus.LED_Out, exp_led(m, 1));
    end
`endif
  endtask

  task automatic test_reset_midrun();
    int m;
    m = int'($urandom_range(1, 3));
    do_reset();
    press_mode(m);
    launch();
    repeat (9) tick();
    n_checks++;
    if (bus.LED_Out !== exp_led(m, 2)) begin
      n_fail++;
      $display("FAIL midrun_tick2: got %h expected %h", bus.LED_Out, exp_led(m, 2));
    end
    #2;
    start = 1'b0;
    #1;
    n_checks++;
    if ({bus.LED_Out, bus.mode, bus.busy, bus.done} !== 12'h000) begin
      n_fail++;
      $display("FAIL midrun_async_reset: got %h expected 000", {bus.LED_Out, bus.mode, bus.busy, bus.done});
    end
    repeat (3) tick();
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({bus.LED_Out, bus.mode, bus.busy, bus.done} !== 12'h000) begin
        n_fail++;
        $display("FAIL midrun_no_done i=%0d: got %h expected 000", i,
                 {bus.LED_Out, bus.mode, bus.busy, bus.done});
      end
    end
  endtask

  initial begin
    bus.btn_go = 1'b0;
    bus.btn_mode = 1'b0;
    bus.pause = 1'b0;
    test_reset();
    test_bounce();
    test_mode0_run();
    test_patterns16();
    test_pause();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
